line_adapter: RTL and testbench
===============================

LINE_ADAPTER -- requirements
Module: line_adapter

Interface
REQ-001 Parameter: ENABLE_BUFFER, default 1, meaning 1 = line buffer may satisfy hits; 0 = every request misses.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 l1_address  in  16  L1 byte address of 128-bit line; [4] selects half of 256-bit L2 line.
REQ-005 l1_read  in  1  L1 line read request, held until l1_resp.
REQ-006 l1_write  in  1  L1 line write request, held until l1_resp.
REQ-007 l1_wdata  in  128  L1 write line, stable while l1_write held.
REQ-008 l1_rdata  out  128  read line, valid in l1_resp cycle.
REQ-009 l1_resp  out  1  one-cycle completion pulse to L1.
REQ-010 l2_address  out  16  L2 line address, {l1_address[15:5], 5'b0}.
REQ-011 l2_read  out  1  L2 line read request.
REQ-012 l2_write  out  1  L2 line write request.
REQ-013 l2_wdata  out  256  L2 write line.
REQ-014 l2_rdata  in  256  L2 read line, valid when l2_resp high.
REQ-015 l2_resp  in  1  L2 completion pulse.

Function
REQ-016 Block SHALL be the responder on the L1 128-bit line interface and the initiator on the L2 256-bit line interface.
REQ-017 State: one 256-bit line buffer, 11-bit tag (address[15:5]), valid bit; hit = ENABLE_BUFFER & valid & tag == l1_address[15:5].
REQ-018 FSM states SHALL be IDLE, FETCH, WRITE, RESPOND.
REQ-019 IDLE: read hit -> RESPOND; read miss -> FETCH; write hit -> merge l1_wdata into buffer half [address[4]], -> WRITE; write miss -> FETCH; no request -> IDLE.
REQ-020 l1_read and l1_write both high SHALL be treated as write.
REQ-021 FETCH: l2_read=1, l2_address aligned; on l2_resp load buffer from l2_rdata, set tag, valid=1; read -> RESPOND; write -> merge l1_wdata same edge, -> WRITE.
REQ-022 WRITE: l2_write=1, l2_wdata=buffer (write-through); on l2_resp -> RESPOND.
REQ-023 RESPOND: l1_resp=1 for exactly one cycle, l1_rdata = buffer[127:0] if address[4]=0 else buffer[255:128]; -> IDLE.
REQ-024 l1_rdata SHALL be 0 outside RESPOND; l2_wdata SHALL be 0 outside WRITE.
REQ-025 l2_read/l2_write SHALL stay asserted, address stable, until l2_resp; deasserted the cycle after l2_resp.
REQ-026 Latency (request sampled in IDLE at cycle 0): hit read -> l1_resp cycle 1; miss read with l2_resp at cycle n -> l1_resp cycle n+1; write hit with l2_resp at cycle n -> l1_resp cycle n+1.
REQ-027 l2_resp outside FETCH/WRITE SHALL be ignored.
REQ-028 l1_address half bit [4] SHALL be latched on leaving IDLE for RESPOND selection.

Reset
REQ-029 On reset: state IDLE, valid=0, tag=0, buffer=0, all outputs 0 next cycle.
REQ-030 Reset mid-FETCH/WRITE SHALL abort: l2_read/l2_write drop next cycle, no l1_resp, buffer invalidated; later l2_resp ignored.

Verification
REQ-031 Reset, l1_read addr 0x1230, l2_resp at cycle 4 with rdata upper=A, lower=B -> l2_read cycles 1-4, addr 0x1220, l1_resp cycle 5, l1_rdata=A.
REQ-032 Then l1_read 0x1220 -> no l2_read, l1_resp next cycle, l1_rdata=B.
REQ-033 l1_write 0x1230 wdata=C (buffer hit) -> l2_write, l2_wdata={C,B}, l1_resp cycle after l2_resp.
REQ-034 l1_write 0x4000 wdata=D (miss), L2 line {E,F} -> l2_read then l2_write {E,D}, one l1_resp.
REQ-035 Reset asserted during FETCH -> l2_read 0 next cycle, no l1_resp, subsequent read of same line misses.
REQ-036 ENABLE_BUFFER=0, two reads 0x1230 -> two L2 fetches; stray l2_resp in IDLE -> no state change.

Source files
------------

// File: rtl/line_adapter.sv
// line_adapter: bridges 128-bit L1 line requests onto a 256-bit L2 line port through a one-line write-through buffer.
module line_adapter #(
   parameter bit ENABLE_BUFFER = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [15:0]  l1_address,
   input  logic         l1_read,
   input  logic         l1_write,
   input  logic [127:0] l1_wdata,
   output logic [127:0] l1_rdata,
   output logic         l1_resp,
   output logic [15:0]  l2_address,
   output logic         l2_read,
   output logic         l2_write,
   output logic [255:0] l2_wdata,
   input  logic [255:0] l2_rdata,
   input  logic         l2_resp
);
   typedef enum logic [1:0] {IDLE, FETCH, WRITE, RESPOND} state_t;
   state_t        state_q;
   logic [255:0]  buf_q;
   logic [10:0]   tag_q, line_q;
   logic          valid_q, half_q, wr_q, l1_resp_q, l2_read_q, l2_write_q;
   logic          hit;
   function automatic logic [255:0] merge(input logic [255:0] b, input logic h, input logic [127:0] d);
      return h ? {d, b[127:0]} : {b[255:128], d};
   endfunction
   assign hit        = ENABLE_BUFFER && valid_q && (tag_q == l1_address[15:5]);
   assign l1_resp    = l1_resp_q;
   assign l2_read    = l2_read_q;
   assign l2_write   = l2_write_q;
   assign l2_address = {line_q, 5'b0};
   assign l1_rdata   = (state_q == RESPOND) ? (half_q ? buf_q[255:128] : buf_q[127:0]) : 128'b0;
   assign l2_wdata   = (state_q == WRITE) ? buf_q : 256'b0;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         buf_q      <= '0;
         tag_q      <= '0;
         line_q     <= '0;
         valid_q    <= 1'b0;
         half_q     <= 1'b0;
         wr_q       <= 1'b0;
         l1_resp_q  <= 1'b0;
         l2_read_q  <= 1'b0;
         l2_write_q <= 1'b0;
      end else begin
         l1_resp_q <= 1'b0;
         case (state_q)
            IDLE: if (l1_read || l1_write) begin
               line_q <= l1_address[15:5];
               half_q <= l1_address[4];
               wr_q   <= l1_write;
               if (hit && l1_write) begin
                  buf_q      <= merge(buf_q, l1_address[4], l1_wdata);
                  l2_write_q <= 1'b1;
                  state_q    <= WRITE;
               end else if (hit) begin
                  l1_resp_q <= 1'b1;
                  state_q   <= RESPOND;
               end else begin
                  l2_read_q <= 1'b1;
                  state_q   <= FETCH;
               end
            end
            // A write miss merges the L1 half into the fetched line before writing it back
            FETCH: if (l2_resp) begin
               buf_q      <= wr_q ? merge(l2_rdata, half_q, l1_wdata) : l2_rdata;
               tag_q      <= line_q;
               valid_q    <= 1'b1;
               l2_read_q  <= 1'b0;
               l2_write_q <= wr_q;
               l1_resp_q  <= !wr_q;
               state_q    <= wr_q ? WRITE : RESPOND;
            end
            WRITE: if (l2_resp) begin
               l2_write_q <= 1'b0;
               l1_resp_q  <= 1'b1;
               state_q    <= RESPOND;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_line_adapter.sv
// tb_line_adapter: table-driven scoreboard bench for line_adapter, with and without the line buffer.
module tb_line_adapter;
   logic clk = 1'b0, rst = 1'b0, sel = 1'b0;
   always #5 clk = ~clk;
   logic rd = 1'b0, wr = 1'b0, resp = 1'b0;
   logic [15:0] addr = '0;
   logic [127:0] wd = '0;
   logic [255:0] rdat = '0;
   logic [127:0] m_rdata, n_rdata, o_rdata;
   logic m_resp, n_resp, o_resp, m_l2r, n_l2r, o_l2r, m_l2w, n_l2w, o_l2w;
   logic [15:0] m_l2a, n_l2a, o_l2a;
   logic [255:0] m_l2wd, n_l2wd, o_l2wd;
   line_adapter dut (
      .clk(clk), .reset(rst), .l1_address(addr), .l1_read(rd & ~sel), .l1_write(wr & ~sel),
      .l1_wdata(wd), .l1_rdata(m_rdata), .l1_resp(m_resp), .l2_address(m_l2a), .l2_read(m_l2r),
      .l2_write(m_l2w), .l2_wdata(m_l2wd), .l2_rdata(rdat), .l2_resp(resp & ~sel));
   line_adapter #(.ENABLE_BUFFER(1'b0)) dut0 (
      .clk(clk), .reset(rst), .l1_address(addr), .l1_read(rd & sel), .l1_write(wr & sel),
      .l1_wdata(wd), .l1_rdata(n_rdata), .l1_resp(n_resp), .l2_address(n_l2a), .l2_read(n_l2r),
      .l2_write(n_l2w), .l2_wdata(n_l2wd), .l2_rdata(rdat), .l2_resp(resp & sel));
   assign o_rdata = sel ? n_rdata : m_rdata;
   assign o_resp  = sel ? n_resp  : m_resp;
   assign o_l2r   = sel ? n_l2r   : m_l2r;
   assign o_l2w   = sel ? n_l2w   : m_l2w;
   assign o_l2a   = sel ? n_l2a   : m_l2a;
   assign o_l2wd  = sel ? n_l2wd  : m_l2wd;
   localparam logic [127:0] A = {4{32'hAAAA_0001}}, B = {4{32'hBBBB_0002}}, C = {4{32'hCCCC_0003}};
   localparam logic [127:0] D = {4{32'hDDDD_0004}}, E = {4{32'hEEEE_0005}}, F = {4{32'hFFFF_0006}};
   localparam logic [127:0] G = {4{32'h1111_0007}}, H = {4{32'h2222_0008}}, I = {4{32'h3333_0009}};
   typedef struct {
      logic r, w;
      logic [15:0] a;
      logic [127:0] d;
      int dly;
      logic [127:0] rdata;
      int lat;
      bit fetch, wb;
      logic [255:0] l2wd;
   } vec_t;
   typedef struct {
      logic [127:0] rdata;
      int lat;
   } exp_t;
   exp_t sb[$];
   logic [255:0] l2mem [logic [10:0]];
   int checks = 0, errors = 0;
   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask
   task automatic transact(input vec_t v, input string name);
      int c, cnt;
      bit got_f, got_w, done;
      exp_t e;
      sb.push_back('{v.rdata, v.lat});
      rd = v.r; wr = v.w; addr = v.a; wd = v.d;
      c = 0; cnt = 0; got_f = 0; got_w = 0; done = 0;
      while (!done && c < 60) begin
         @(negedge clk);
         c++;
         resp = 1'b0;
         if (!o_l2w) chk({name, " l2_wdata_idle"}, o_l2wd, 256'b0);
         if (!o_resp) chk({name, " l1_rdata_idle"}, {128'b0, o_rdata}, 256'b0);
         if (o_l2r || o_l2w) begin
            chk({name, " l2_address"}, {240'b0, o_l2a}, {240'b0, v.a[15:5], 5'b0});
            got_f |= o_l2r;
            if (o_l2w) begin
               got_w = 1;
               chk({name, " l2_wdata"}, o_l2wd, v.l2wd);
            end
            cnt++;
            if (cnt == v.dly) begin
               resp = 1'b1;
               cnt = 0;
               if (o_l2r) rdat = l2mem.exists(v.a[15:5]) ? l2mem[v.a[15:5]] : 256'b0;
               else l2mem[v.a[15:5]] = o_l2wd;
            end
         end
         if (o_resp) begin
            e = sb.pop_front();
            chk({name, " l1_rdata"}, {128'b0, o_rdata}, {128'b0, e.rdata});
            chk({name, " latency"}, c, e.lat);
            done = 1;
            rd = 1'b0; wr = 1'b0;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL %s timeout actual=no l1_resp required=l1_resp", name);
         rd = 1'b0; wr = 1'b0;
         if (sb.size() > 0) void'(sb.pop_front());
      end
      chk({name, " fetched"}, got_f, v.fetch);
      chk({name, " wrote"}, got_w, v.wb);
      @(negedge clk);
      resp = 1'b0;
      chk({name, " single_resp"}, o_resp, 1'b0);
   endtask
   vec_t tbl[7];
   vec_t v;
   initial begin
      l2mem[11'h091] = {A, B};
      l2mem[11'h200] = {E, F};
      l2mem[11'h280] = {H, I};
      tbl[0] = '{1'b1, 1'b0, 16'h1230, '0, 4, A, 5, 1'b1, 1'b0, '0};
      tbl[1] = '{1'b1, 1'b0, 16'h1220, '0, 1, B, 1, 1'b0, 1'b0, '0};
      tbl[2] = '{1'b0, 1'b1, 16'h1230, C, 3, C, 4, 1'b0, 1'b1, {C, B}};
      tbl[3] = '{1'b0, 1'b1, 16'h4000, D, 2, D, 5, 1'b1, 1'b1, {E, D}};
      tbl[4] = '{1'b1, 1'b0, 16'h4010, '0, 1, E, 1, 1'b0, 1'b0, '0};
      tbl[5] = '{1'b1, 1'b0, 16'h1230, '0, 1, C, 2, 1'b1, 1'b0, '0};
      tbl[6] = '{1'b1, 1'b1, 16'h1220, G, 1, G, 2, 1'b0, 1'b1, {C, G}};
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset l1_resp", o_resp, 1'b0);
      chk("reset l2_read", o_l2r, 1'b0);
      chk("reset l2_write", o_l2w, 1'b0);
      chk("reset l2_address", {240'b0, o_l2a}, 256'b0);
      chk("reset l1_rdata", {128'b0, o_rdata}, 256'b0);
      chk("reset l2_wdata", o_l2wd, 256'b0);
      for (int k = 0; k < 7; k++) transact(tbl[k], $sformatf("vec%0d", k));
      // abort a fetch with reset, then prove nothing completes and the buffer was dropped
      rd = 1'b1; addr = 16'h5000;
      repeat (2) @(negedge clk);
      chk("abort fetching", o_l2r, 1'b1);
      rst = 1'b1; rd = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("abort l2_read", o_l2r, 1'b0);
      chk("abort l1_resp", o_resp, 1'b0);
      resp = 1'b1;
      @(negedge clk);
      resp = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("stray resp l1_resp", o_resp, 1'b0);
         chk("stray resp l2_read", o_l2r, 1'b0);
      end
      v = '{1'b1, 1'b0, 16'h1220, '0, 2, G, 3, 1'b1, 1'b0, '0};
      transact(v, "post_reset_miss");
      v = '{1'b1, 1'b0, 16'h5000, '0, 1, I, 2, 1'b1, 1'b0, '0};
      transact(v, "aborted_line");
      // buffer disabled: stray response in idle, then every read goes to L2
      sel = 1'b1;
      @(negedge clk);
      resp = 1'b1;
      @(negedge clk);
      resp = 1'b0;
      chk("nobuf stray l1_resp", o_resp, 1'b0);
      chk("nobuf stray l2_read", o_l2r, 1'b0);
      v = '{1'b1, 1'b0, 16'h1230, '0, 2, C, 3, 1'b1, 1'b0, '0};
      transact(v, "nobuf_read1");
      transact(v, "nobuf_read2");
      chk("scoreboard empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
